control_unit: RTL and testbench

//  Multi-cycle instruction sequencer that drives the processor datapath control inputs.

---
 rtl/control_unit_pkg.sv | 54 +++++
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit_run_sync.sv | 28 ++
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared types for the instruction sequencer and its datapath neighbours:
//   ALU function select, PC source select, opcode mnemonics and FSM states.
package control_unit_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int CNT_N_DEFAULT = 16;

  // Shared with datapath / alu.
  typedef enum logic [2:0] {
    FnA   = 3'd0,
    FnAdd = 3'd1,
    FnSub = 3'd2,
    FnAnd = 3'd3,
    FnOr  = 3'd4
  } alu_functions_t;

  typedef enum logic {
    PcInc = 1'b0,
    PcJmp = 1'b1
  } PcSel_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDIH = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_IN   = 4'h5,
    OP_ADD  = 4'h6,
    OP_SUB  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_ADDI = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JNZ  = 4'hD,
    OP_RSVD = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Map the top nibble of an instruction word onto the opcode enum.
  function automatic opcode_t get_opcode(input logic [3:0] nib);
    return opcode_t'(nib);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundle between the sequencer and the datapath.
//   master (control unit): reads Instr, AccZero; drives all datapath controls.
//   slave  (datapath)    : drives Instr, AccZero; reads all datapath controls.
interface control_unit_if import control_unit_pkg::*; #(
  parameter int n = N_DEFAULT
) ();

  logic [n-1:0]   Instr;
  logic           AccZero;
  logic           RegWe;
  logic           ImmSel;
  logic           WDataSel;
  logic           AccStore;
  logic           Op1Sel;
  logic           PcWe;
  alu_functions_t AluOp;
  PcSel_t         PcSel;

  modport master (
    input  Instr, AccZero,
    output RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, AluOp, PcSel
  );

  modport slave (
    output Instr, AccZero,
    input  RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, AluOp, PcSel
  );

endinterface

// File: rtl/control_unit_run_sync.sv
// run_sync
//   Two-flop synchroniser for an asynchronous push-button plus rising-edge
//   detector. Edge is high for exactly one Clock cycle per synchronised rise.
//   Ports: Clock, nReset (async active-low), Async (raw input), Edge (pulse).
module run_sync (
  input  logic Clock,
  input  logic nReset,
  input  logic Async,
  output logic Edge
);

  logic [1:0] sync_r;
  logic       prev_r;

  // Synchroniser chain and previous-value flop for edge detection.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], Async};
      prev_r <= sync_r[1];
    end
  end

  assign Edge = sync_r[1] & ~prev_r;

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle sequencer: each instruction spends one cycle in S_FETCH while
//   program memory settles and one in S_EXEC where datapath controls are
//   decoded from the opcode. Supports HALT, single-step and a retired count.
//   Ports: Clock, nReset (async active-low), bus (control_unit_if.master:
//   Instr/AccZero in, datapath controls out), Run (async button), Step
//   (single-step level), Halted, InstrCount.
module control_unit import control_unit_pkg::*; #(
  parameter int n     = N_DEFAULT,
  parameter int cnt_n = CNT_N_DEFAULT
) (
  input  logic              Clock,
  input  logic              nReset,
  control_unit_if.master    bus,
  input  logic              Run,
  input  logic              Step,
  output logic              Halted,
  output logic [cnt_n-1:0]  InstrCount
);

  state_t           state_r;
  state_t           next_state;
  logic [cnt_n-1:0] count_r;
  logic             count_en;
  logic             run_edge;
  opcode_t          opcode;
  logic             unused_operand;

  logic             reg_we;
  logic             imm_sel;
  logic             wdata_sel;
  logic             acc_store;
  logic             op1_sel;
  logic             pc_we;
  alu_functions_t   alu_op;
  PcSel_t           pc_sel;

  run_sync u_run_sync (
    .Clock  (Clock),
    .nReset (nReset),
    .Async  (Run),
    .Edge   (run_edge)
  );

  assign opcode         = get_opcode(bus.Instr[n-1 -: 4]);
  // Operand bits steer the datapath directly; the sequencer never looks at them.
  assign unused_operand = ^bus.Instr[n-5:0];

  // Next state and control decode. Controls are only non-idle in S_EXEC and
  // the S_HALT resume cycle, so an async reset (state -> S_FETCH) kills every
  // enable immediately without waiting for a clock edge.
  always_comb begin
    next_state = state_r;
    count_en   = 1'b0;
    reg_we     = 1'b0;
    imm_sel    = 1'b0;
    wdata_sel  = 1'b0;
    acc_store  = 1'b0;
    op1_sel    = 1'b0;
    pc_we      = 1'b0;
    alu_op     = FnA;
    pc_sel     = PcInc;
    case (state_r)
      S_FETCH: next_state = S_EXEC;
      S_EXEC: begin
        pc_we      = 1'b1;
        count_en   = 1'b1;
        next_state = Step ? S_WAIT : S_FETCH;
        case (opcode)
          OP_LDI:  begin op1_sel = 1'b1; acc_store = 1'b1; end
          OP_LDIH: begin op1_sel = 1'b1; imm_sel = 1'b1; acc_store = 1'b1; end
          OP_LD:   acc_store = 1'b1;
          OP_ST:   reg_we = 1'b1;
          OP_IN:   begin reg_we = 1'b1; wdata_sel = 1'b1; end
          OP_ADD:  begin alu_op = FnAdd; acc_store = 1'b1; end
          OP_SUB:  begin alu_op = FnSub; acc_store = 1'b1; end
          OP_AND:  begin alu_op = FnAnd; acc_store = 1'b1; end
          OP_OR:   begin alu_op = FnOr;  acc_store = 1'b1; end
          OP_ADDI: begin op1_sel = 1'b1; alu_op = FnAdd; acc_store = 1'b1; end
          OP_JMP:  pc_sel = PcJmp;
          OP_JZ:   pc_sel = bus.AccZero ? PcJmp : PcInc;
          OP_JNZ:  pc_sel = bus.AccZero ? PcInc : PcJmp;
          OP_HALT: begin
            pc_we      = 1'b0;
            count_en   = 1'b0;
            next_state = S_HALT;
          end
          default: pc_sel = PcInc;  // NOP and reserved
        endcase
      end
      // Pc still points at the HALT word; the resume cycle steps past it.
      S_HALT: begin
        if (run_edge) begin
          pc_we      = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_HALT;
        end
      end
      // Pc already advanced in S_EXEC, so resuming needs no write.
      S_WAIT: begin
        if (run_edge) begin
          next_state = S_FETCH;
        end else begin
          next_state = S_WAIT;
        end
      end
      default: next_state = S_FETCH;
    endcase
  end

  // FSM state and retired-instruction counter (wraps silently).
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= S_FETCH;
      count_r <= {cnt_n{1'b0}};
    end else begin
      state_r <= next_state;
      if (count_en) begin
        count_r <= count_r + cnt_n'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.RegWe    = reg_we;
  assign bus.ImmSel   = imm_sel;
  assign bus.WDataSel = wdata_sel;
  assign bus.AccStore = acc_store;
  assign bus.Op1Sel   = op1_sel;
  assign bus.PcWe     = pc_we;
  assign bus.AluOp    = alu_op;
  assign bus.PcSel    = pc_sel;
  assign Halted       = (state_r == S_HALT) || (state_r == S_WAIT);
  assign InstrCount   = count_r;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Directed bench for control_unit. A second instance with a 4-bit counter
//   exercises the counter wrap in a few dozen cycles.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Run;
  logic        Step;
  logic        Halted;
  logic [15:0] InstrCount;

  logic        wrap_run;
  logic        wrap_step;
  logic        wrap_halted;
  logic [3:0]  wrap_count;

  int n_cmp = 0;
  int n_err = 0;

  control_unit_if #(.n(8)) bus  ();
  control_unit_if #(.n(8)) wbus ();

  control_unit #(.n(8), .cnt_n(16)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .bus        (bus),
    .Run        (Run),
    .Step       (Step),
    .Halted     (Halted),
    .InstrCount (InstrCount)
  );

  control_unit #(.n(8), .cnt_n(4)) u_wrap (
    .Clock      (Clock),
    .nReset     (nReset),
    .bus        (wbus),
    .Run        (wrap_run),
    .Step       (wrap_step),
    .Halted     (wrap_halted),
    .InstrCount (wrap_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present an instruction word during S_FETCH and advance into S_EXEC.
  task automatic to_exec(input logic [7:0] w);
    bus.Instr = w;
    tick();
  endtask

  // From S_HALT: wait for the resume cycle (PcWe high while halted).
  task automatic wait_resume(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (bus.PcWe === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // From S_WAIT: wait until the FSM is back in S_FETCH.
  task automatic wait_unhalt(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (Halted === 1'b0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset      = 1'b0;
    Run         = 1'b0;
    Step        = 1'b0;
    bus.Instr   = 8'h15;
    bus.AccZero = 1'b0;
    wbus.Instr  = 8'h00;
    wbus.AccZero = 1'b0;
    wrap_run    = 1'b0;
    wrap_step   = 1'b0;

    // 1. Reset state, then LDI 5
    #12;
    chk("rst_pcwe",  32'(bus.PcWe), 32'd0);
    chk("rst_aluop", 32'(bus.AluOp), 32'(FnA));
    chk("rst_pcsel", 32'(bus.PcSel), 32'(PcInc));
    chk("rst_halt",  32'(Halted), 32'd0);
    chk("rst_cnt",   32'(InstrCount), 32'd0);
    #1 nReset = 1'b1;
    chk("fetch_pcwe",  32'(bus.PcWe), 32'd0);
    chk("fetch_accst", 32'(bus.AccStore), 32'd0);
    tick();
    chk("ldi_op1",   32'(bus.Op1Sel), 32'd1);
    chk("ldi_immsel",32'(bus.ImmSel), 32'd0);
    chk("ldi_accst", 32'(bus.AccStore), 32'd1);
    chk("ldi_pcwe",  32'(bus.PcWe), 32'd1);
    chk("ldi_aluop", 32'(bus.AluOp), 32'(FnA));
    chk("ldi_cnt0",  32'(InstrCount), 32'd0);
    tick();
    chk("ldi_cnt1",  32'(InstrCount), 32'd1);

    // 2. ALU, store, input and immediate forms
    to_exec(8'h63);
    chk("add_aluop", 32'(bus.AluOp), 32'(FnAdd));
    chk("add_op1",   32'(bus.Op1Sel), 32'd0);
    chk("add_accst", 32'(bus.AccStore), 32'd1);
    tick();
    to_exec(8'h42);
    chk("st_regwe",  32'(bus.RegWe), 32'd1);
    chk("st_wdsel",  32'(bus.WDataSel), 32'd0);
    chk("st_accst",  32'(bus.AccStore), 32'd0);
    tick();
    to_exec(8'h54);
    chk("in_regwe",  32'(bus.RegWe), 32'd1);
    chk("in_wdsel",  32'(bus.WDataSel), 32'd1);
    tick();
    to_exec(8'h2A);
    chk("ldih_imm",  32'(bus.ImmSel), 32'd1);
    chk("ldih_op1",  32'(bus.Op1Sel), 32'd1);
    chk("ldih_accst",32'(bus.AccStore), 32'd1);
    tick();
    to_exec(8'hA1);
    chk("addi_alu",  32'(bus.AluOp), 32'(FnAdd));
    chk("addi_op1",  32'(bus.Op1Sel), 32'd1);
    tick();
    to_exec(8'h71);
    chk("sub_alu",   32'(bus.AluOp), 32'(FnSub));
    tick();
    to_exec(8'h81);
    chk("and_alu",   32'(bus.AluOp), 32'(FnAnd));
    tick();
    to_exec(8'h91);
    chk("or_alu",    32'(bus.AluOp), 32'(FnOr));
    tick();
    chk("cnt_after9", 32'(InstrCount), 32'd9);

    // 3. Branches
    bus.AccZero = 1'b1;
    to_exec(8'hC1);
    chk("jz_taken_sel", 32'(bus.PcSel), 32'(PcJmp));
    chk("jz_taken_we",  32'(bus.PcWe), 32'd1);
    tick();
    bus.AccZero = 1'b0;
    to_exec(8'hC1);
    chk("jz_not_sel",   32'(bus.PcSel), 32'(PcInc));
    chk("jz_not_we",    32'(bus.PcWe), 32'd1);
    tick();
    to_exec(8'hD1);
    chk("jnz_taken_sel", 32'(bus.PcSel), 32'(PcJmp));
    tick();
    to_exec(8'hB3);
    chk("jmp_sel",   32'(bus.PcSel), 32'(PcJmp));
    chk("jmp_accst", 32'(bus.AccStore), 32'd0);
    chk("jmp_alu",   32'(bus.AluOp), 32'(FnA));
    tick();
    to_exec(8'hE0);
    chk("rsvd_pcwe",  32'(bus.PcWe), 32'd1);
    chk("rsvd_regwe", 32'(bus.RegWe), 32'd0);
    chk("rsvd_accst", 32'(bus.AccStore), 32'd0);
    tick();
    chk("cnt_after14", 32'(InstrCount), 32'd14);

    // 4. HALT and resume
    to_exec(8'hF0);
    chk("halt_pcwe", 32'(bus.PcWe), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_held", 32'(Halted), 32'd1);
      chk("halt_pcwe_idle", 32'(bus.PcWe), 32'd0);
    end
    chk("halt_cnt", 32'(InstrCount), 32'd14);
    Run = 1'b1;
    wait_resume("halt_resume_seen");
    chk("resume_pcsel",  32'(bus.PcSel), 32'(PcInc));
    chk("resume_halted", 32'(Halted), 32'd1);
    tick();
    chk("resume_fetch_halted", 32'(Halted), 32'd0);
    chk("resume_fetch_pcwe",   32'(bus.PcWe), 32'd0);
    chk("resume_cnt",          32'(InstrCount), 32'd14);

    // 5. Single-step
    Run  = 1'b0;
    Step = 1'b1;
    to_exec(8'h00);
    chk("step1_pcwe", 32'(bus.PcWe), 32'd1);
    tick();
    chk("step1_halted", 32'(Halted), 32'd1);
    chk("step1_cnt",    32'(InstrCount), 32'd15);
    repeat (3) tick();
    chk("step1_wait", 32'(Halted), 32'd1);
    Run = 1'b1;
    wait_unhalt("step1_release");
    to_exec(8'h00);
    tick();
    chk("step2_halted", 32'(Halted), 32'd1);
    chk("step2_cnt",    32'(InstrCount), 32'd16);
    repeat (10) tick();
    chk("run_held_halted", 32'(Halted), 32'd1);
    chk("run_held_cnt",    32'(InstrCount), 32'd16);
    Run = 1'b0;
    repeat (3) tick();
    Run = 1'b1;
    wait_unhalt("step2_release");
    to_exec(8'h00);
    tick();
    chk("step3_cnt",    32'(InstrCount), 32'd17);
    chk("step3_halted", 32'(Halted), 32'd1);
    Step = 1'b0;
    Run  = 1'b0;
    repeat (3) tick();
    Run = 1'b1;
    wait_unhalt("step3_release");
    Run = 1'b0;

    // 6. Async reset mid-S_EXEC, then counter wrap on the 4-bit instance
    to_exec(8'h42);
    chk("mid_st_regwe", 32'(bus.RegWe), 32'd1);
    #1 nReset = 1'b0;
    #1;
    chk("arst_regwe", 32'(bus.RegWe), 32'd0);
    chk("arst_pcwe",  32'(bus.PcWe), 32'd0);
    chk("arst_cnt",   32'(InstrCount), 32'd0);
    chk("arst_wcnt",  32'(wrap_count), 32'd0);
    #1 nReset = 1'b1;
    chk("arst_fetch_pcwe", 32'(bus.PcWe), 32'd0);
    tick();
    chk("restart_regwe", 32'(bus.RegWe), 32'd1);
    tick();
    chk("restart_cnt", 32'(InstrCount), 32'd1);
    repeat (28) tick();
    chk("cnt_15",   32'(InstrCount), 32'd15);
    chk("wrap_max", 32'(wrap_count), 32'hF);
    repeat (2) tick();
    chk("cnt_16",    32'(InstrCount), 32'd16);
    chk("wrap_zero", 32'(wrap_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
